// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one FIFO write port
// among NREQ requesters; each grant is one contiguous burst.
module fifo_wr_arbiter #(
    parameter int NREQ   = 4,
    parameter int DWIDTH = 8,
    parameter int BURST  = 4,
    localparam int IW    = $clog2(NREQ),
    localparam int CW    = $clog2(BURST + 1)
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ-1:0]        req_last,
    input  logic [NREQ*DWIDTH-1:0] req_data,
    output logic [NREQ-1:0]        req_ready,
    input  logic                   fifo_wfull,
    output logic                   fifo_wren,
    output logic [DWIDTH-1:0]      fifo_wdata,
    output logic [NREQ-1:0]        grant,
    output logic [IW-1:0]          grant_id,
    output logic                   busy
);

    typedef enum logic {IDLE, GRANT} state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] gid_q, gid_d;
    logic [IW-1:0] rr_q, rr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [IW-1:0] winner;
    logic [IW:0]   idx;
    logic          any_valid;
    logic          own_valid;
    logic          own_last;
    logic          accept;
    logic          cnt_hit;
    logic          release_now;
    logic [IW-1:0] next_ptr;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            gid_q   <= '0;
            rr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gid_q   <= gid_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
        end
    end

    // first valid requester at or after the rr pointer, wrapping
    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        idx       = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = {1'b0, rr_q} + (IW+1)'(i);
            if (idx >= (IW+1)'(NREQ)) begin
                idx = idx - (IW+1)'(NREQ);
            end
            if (!any_valid && req_valid[idx[IW-1:0]]) begin
                any_valid = 1'b1;
                winner    = idx[IW-1:0];
            end
        end
    end

    assign own_valid   = req_valid[gid_q];
    assign own_last    = req_last[gid_q];
    assign accept      = (state_q == GRANT) & own_valid & ~fifo_wfull;
    assign cnt_hit     = (cnt_q + CW'(1)) == CW'(BURST);
    assign release_now = (state_q == GRANT) &
                         (~own_valid | (accept & (own_last | cnt_hit)));
    assign next_ptr    = (gid_q == IW'(NREQ - 1)) ? '0 : gid_q + IW'(1);

    always_comb begin
        state_d = state_q;
        gid_d   = gid_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    state_d = GRANT;
                    gid_d   = winner;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                if (accept) begin
                    cnt_d = cnt_q + CW'(1);
                end
                if (release_now) begin
                    state_d = IDLE;
                    gid_d   = '0;
                    cnt_d   = '0;
                    rr_d    = next_ptr;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        grant      = '0;
        req_ready  = '0;
        fifo_wren  = 1'b0;
        busy       = 1'b0;
        fifo_wdata = req_data[gid_q*DWIDTH +: DWIDTH];
        if (state_q == GRANT) begin
            grant[gid_q]     = 1'b1;
            req_ready[gid_q] = ~fifo_wfull;
            fifo_wren        = accept;
            busy             = 1'b1;
        end
    end

    assign grant_id = gid_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed and random stimulus against a
// packet-level reference model, checked through a scoreboard.
module tb_fifo_wr_arbiter;

    localparam int NREQ   = 4;
    localparam int DWIDTH = 8;
    localparam int BURST  = 4;

    logic                   clk = 1'b0;
    logic                   rstn = 1'b0;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_last;
    logic [NREQ*DWIDTH-1:0] req_data;
    logic [NREQ-1:0]        req_ready;
    logic                   fifo_wfull;
    logic                   fifo_wren;
    logic [DWIDTH-1:0]      fifo_wdata;
    logic [NREQ-1:0]        grant;
    logic [1:0]             grant_id;
    logic                   busy;

    fifo_wr_arbiter #(.NREQ(NREQ), .DWIDTH(DWIDTH), .BURST(BURST)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
        .req_ready(req_ready), .fifo_wfull(fifo_wfull),
        .fifo_wren(fifo_wren), .fifo_wdata(fifo_wdata),
        .grant(grant), .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NREQ-1:0] grant;
        logic [1:0]      gid;
        logic            busy;
        logic [NREQ-1:0] ready;
        logic            wren;
    } exp_t;

    exp_t              cyc_q[$];
    logic [DWIDTH-1:0] wd_q[$];
    int checks = 0;
    int errors = 0;

    bit                v[NREQ];
    bit                l[NREQ];
    bit                lf[NREQ];
    logic [DWIDTH-1:0] d[NREQ];
    int                rem[NREQ];
    bit                full;

    int m_owner = -1;
    int m_beats = 0;
    int m_ptr   = 0;
    bit acc[NREQ];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic start(int i, logic [DWIDTH-1:0] data, int n, bit lastf);
        v[i]   = 1'b1;
        d[i]   = data;
        rem[i] = n;
        lf[i]  = lastf;
        l[i]   = (n == 1) && lastf;
    endtask

    task automatic advance(int i);
        if (rem[i] > 1) begin
            rem[i]--;
            d[i] = d[i] + 8'd1;
            l[i] = (rem[i] == 1) && lf[i];
        end else begin
            v[i]   = 1'b0;
            l[i]   = 1'b0;
            rem[i] = 0;
        end
    endtask

    // reference: one owner at a time, burst ends on last, cap or give-up
    task automatic model_step();
        for (int i = 0; i < NREQ; i++) acc[i] = 1'b0;
        if (!rstn) begin
            m_owner = -1;
            m_beats = 0;
            m_ptr   = 0;
        end else if (m_owner < 0) begin
            for (int k = 0; k < NREQ; k++) begin
                int c;
                c = (m_ptr + k) % NREQ;
                if (v[c]) begin
                    m_owner = c;
                    m_beats = 0;
                    break;
                end
            end
        end else begin
            int g;
            bit w;
            g = m_owner;
            w = v[g] && !full;
            if (w) begin
                acc[g] = 1'b1;
                m_beats++;
            end
            if (!v[g] || (w && (l[g] || m_beats == BURST))) begin
                m_ptr   = (g + 1) % NREQ;
                m_owner = -1;
            end
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i] = v[i];
            req_last[i]  = l[i];
            req_data[i*DWIDTH +: DWIDTH] = d[i];
        end
        fifo_wfull = full;
    endtask

    task automatic cyc();
        exp_t e;
        drive();
        e = '0;
        if (rstn && m_owner >= 0) begin
            e.grant[m_owner] = 1'b1;
            e.gid            = 2'(m_owner);
            e.busy           = 1'b1;
            e.ready[m_owner] = !full;
            e.wren           = v[m_owner] && !full;
            if (e.wren) wd_q.push_back(d[m_owner]);
        end
        cyc_q.push_back(e);
        @(posedge clk);
        model_step();
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (acc[i]) advance(i);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (cyc_q.size() > 0) begin
            e = cyc_q.pop_front();
            check("grant", 32'(grant), 32'(e.grant));
            check("grant_id", 32'(grant_id), 32'(e.gid));
            check("busy", 32'(busy), 32'(e.busy));
            check("req_ready", 32'(req_ready), 32'(e.ready));
            check("fifo_wren", 32'(fifo_wren), 32'(e.wren));
            if (fifo_wren) begin
                checks++;
                if (wd_q.size() == 0) begin
                    errors++;
                    $display("FAIL wdata: write %0h with none expected", fifo_wdata);
                end else if (fifo_wdata !== wd_q[0]) begin
                    errors++;
                    $display("FAIL wdata: got %0h expected %0h", fifo_wdata, wd_q[0]);
                    void'(wd_q.pop_front());
                end else begin
                    void'(wd_q.pop_front());
                end
            end
        end
    end

    initial begin
        int guard;
        for (int i = 0; i < NREQ; i++) begin
            v[i] = 0; l[i] = 0; lf[i] = 0; d[i] = '0; rem[i] = 0;
        end
        full = 1'b0;
        drive();
        #1;
        check("rst_grant", 32'(grant), 0);
        check("rst_grant_id", 32'(grant_id), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_ready", 32'(req_ready), 0);
        check("rst_wren", 32'(fifo_wren), 0);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;

        // single requester, three-beat packet
        start(2, 8'hA0, 3, 1'b1);
        cyc();
        check("single_grant", 32'(grant), 32'h4);
        repeat (5) cyc();
        start(0, 8'h10, 1, 1'b1);
        start(3, 8'h30, 1, 1'b1);
        cyc();
        check("rr_after_single", 32'(grant_id), 3);
        repeat (6) cyc();

        // burst cap with a sole requester
        start(0, 8'h50, 6, 1'b0);
        repeat (12) cyc();

        // fairness with continuous single-beat packets
        for (int c = 0; c < 16; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!v[i]) start(i, 8'(8'h80 + i * 16 + c), 1, 1'b1);
            end
            cyc();
        end
        for (int i = 0; i < NREQ; i++) begin
            v[i] = 0; l[i] = 0;
        end
        repeat (3) cyc();

        // full stall mid-burst
        start(1, 8'hC0, 5, 1'b1);
        for (int c = 0; c < 12; c++) begin
            full = (c >= 3 && c < 6);
            cyc();
        end
        full = 1'b0;
        repeat (2) cyc();

        // owner gives up after one beat
        start(1, 8'hD0, 4, 1'b0);
        start(3, 8'hE0, 1, 1'b1);
        guard = 0;
        while (!acc[1] && guard < 12) begin
            cyc();
            guard++;
        end
        check("vdrop_beat_seen", 32'(acc[1]), 1);
        v[1] = 0; l[1] = 0;
        repeat (6) cyc();

        // reset during beat 2
        start(2, 8'h60, 6, 1'b0);
        guard = 0;
        while (rem[2] > 5 && guard < 12) begin
            cyc();
            guard++;
        end
        check("rst_mid_beat_seen", 32'(rem[2]), 5);
        drive();
        rstn = 1'b0;
        #1;
        check("rst_mid_grant", 32'(grant), 0);
        check("rst_mid_wren", 32'(fifo_wren), 0);
        check("rst_mid_ready", 32'(req_ready), 0);
        repeat (2) cyc();
        rstn = 1'b1;
        v[2] = 0; l[2] = 0;
        start(1, 8'h71, 2, 1'b1);
        start(3, 8'h73, 2, 1'b1);
        cyc();
        check("post_rst_winner", 32'(grant_id), 1);
        repeat (10) cyc();

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!v[i]) begin
                    if ($urandom % 4 == 0) begin
                        start(i, 8'($urandom), 1 + int'($urandom % 6), ($urandom % 2) == 1);
                    end
                end else if ($urandom % 20 == 0) begin
                    v[i] = 0; l[i] = 0; rem[i] = 0;
                end
            end
            full = ($urandom % 4 == 0);
            cyc();
        end
        for (int i = 0; i < NREQ; i++) begin
            v[i] = 0; l[i] = 0;
        end
        full = 1'b0;
        repeat (4) cyc();
        @(negedge clk);
        #1;
        check("cyc_q_drained", 32'(cyc_q.size()), 0);
        check("wdata_q_drained", 32'(wd_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
